// File: rtl/uart_receiver.sv
// UART receive stage: 16x-oversampled line, 2-flop synchronized, one frame at a time.
// Every frame, errored or not, is delivered with a one-clock rx_done pulse.
module uart_receiver #(
    parameter int DATA_BITS = 8,
    parameter int SB_TICKS  = 1,
    parameter int IS_PARITY = 0,
    parameter int PARITY    = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_dout,
    output logic                 rx_done,
    output logic                 parity_err,
    output logic                 frame_err
);
    localparam int NW = $clog2(DATA_BITS) + 1;
    localparam logic [NW-1:0] N_DATA_LAST = NW'(DATA_BITS - 1);
    localparam logic [NW-1:0] N_STOP_LAST = NW'(SB_TICKS - 1);
    localparam logic          PAR_ODD     = (PARITY != 0);
    localparam logic          HAS_PAR     = (IS_PARITY != 0);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    state_t                 state_q, state_d;
    logic                   rx_meta_q, rx_s_q;
    logic [3:0]             s_q, s_d;
    logic [NW-1:0]          n_q, n_d;
    logic [DATA_BITS-1:0]   sr_q, sr_d;
    logic                   armed_q, armed_d;
    logic                   p_bad_q, p_bad_d;
    logic                   ferr_acc_q, ferr_acc_d;
    logic                   frame_end;
    logic [DATA_BITS-1:0]   dout_q, dout_d;
    logic                   done_q, done_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            state_q    <= S_IDLE;
            s_q        <= '0;
            n_q        <= '0;
            sr_q       <= '0;
            armed_q    <= 1'b0;
            p_bad_q    <= 1'b0;
            ferr_acc_q <= 1'b0;
            dout_q     <= '0;
            done_q     <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_s_q     <= rx_meta_q;
            state_q    <= state_d;
            s_q        <= s_d;
            n_q        <= n_d;
            sr_q       <= sr_d;
            armed_q    <= armed_d;
            p_bad_q    <= p_bad_d;
            ferr_acc_q <= ferr_acc_d;
            dout_q     <= dout_d;
            done_q     <= done_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    // armed only sets from a high line in IDLE, so a held-low break never re-triggers.
    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        n_d        = n_q;
        sr_d       = sr_q;
        armed_d    = armed_q;
        p_bad_d    = p_bad_q;
        ferr_acc_d = ferr_acc_q;
        frame_end  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (armed_q && !rx_s_q) begin
                    state_d = S_START;
                    s_d     = '0;
                    armed_d = 1'b0;
                end else if (rx_s_q) begin
                    armed_d = 1'b1;
                end
            end
            S_START: begin
                if (rx_tick) begin
                    if (s_q == 4'd7) begin
                        s_d = '0;
                        if (!rx_s_q) begin
                            state_d    = S_DATA;
                            n_d        = '0;
                            p_bad_d    = 1'b0;
                            ferr_acc_d = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (rx_tick) begin
                    s_d = s_q + 4'd1;
                    if (s_q == 4'd15) begin
                        sr_d = {rx_s_q, sr_q[DATA_BITS-1:1]};
                        if (n_q == N_DATA_LAST) begin
                            state_d = HAS_PAR ? S_PAR : S_STOP;
                            n_d     = '0;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end
                end
            end
            S_PAR: begin
                if (rx_tick) begin
                    s_d = s_q + 4'd1;
                    if (s_q == 4'd15) begin
                        p_bad_d = ^{sr_q, rx_s_q, PAR_ODD};
                        state_d = S_STOP;
                        n_d     = '0;
                    end
                end
            end
            S_STOP: begin
                if (rx_tick) begin
                    s_d = s_q + 4'd1;
                    if (s_q == 4'd15) begin
                        ferr_acc_d = ferr_acc_q | ~rx_s_q;
                        if (n_q == N_STOP_LAST) begin
                            frame_end = 1'b1;
                            state_d   = S_IDLE;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // rx_done is a one-clock pulse; rx_dout and both flags change only alongside it.
    always_comb begin
        done_d = frame_end;
        dout_d = dout_q;
        perr_d = perr_q;
        ferr_d = ferr_q;
        if (frame_end) begin
            dout_d = sr_q;
            perr_d = p_bad_q & HAS_PAR;
            ferr_d = ferr_acc_d;
        end
    end

    assign rx_dout    = dout_q;
    assign rx_done    = done_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: four configurations (8N1, 8E1, 8O1, 8N2) driven with
// directed and random frames; a monitor checks each rx_done against a per-instance queue.
module tb_uart_receiver;
    localparam int TICK_DIV = 3;

    logic        clk;
    logic        reset;
    logic        rx_tick;
    logic [3:0]  rx_line;
    logic [7:0]  dout_w [4];
    logic [3:0]  done_w;
    logic [3:0]  perr_w;
    logic [3:0]  ferr_w;

    logic [9:0]  exp_q [4][$];
    int          total;
    int          bad;
    int          tick_cnt;

    uart_receiver #(.DATA_BITS(8), .SB_TICKS(1), .IS_PARITY(0), .PARITY(0)) u_8n1 (
        .clk(clk), .reset(reset), .rx_tick(rx_tick), .rx(rx_line[0]),
        .rx_dout(dout_w[0]), .rx_done(done_w[0]), .parity_err(perr_w[0]), .frame_err(ferr_w[0]));
    uart_receiver #(.DATA_BITS(8), .SB_TICKS(1), .IS_PARITY(1), .PARITY(0)) u_8e1 (
        .clk(clk), .reset(reset), .rx_tick(rx_tick), .rx(rx_line[1]),
        .rx_dout(dout_w[1]), .rx_done(done_w[1]), .parity_err(perr_w[1]), .frame_err(ferr_w[1]));
    uart_receiver #(.DATA_BITS(8), .SB_TICKS(1), .IS_PARITY(1), .PARITY(1)) u_8o1 (
        .clk(clk), .reset(reset), .rx_tick(rx_tick), .rx(rx_line[2]),
        .rx_dout(dout_w[2]), .rx_done(done_w[2]), .parity_err(perr_w[2]), .frame_err(ferr_w[2]));
    uart_receiver #(.DATA_BITS(8), .SB_TICKS(2), .IS_PARITY(0), .PARITY(0)) u_8n2 (
        .clk(clk), .reset(reset), .rx_tick(rx_tick), .rx(rx_line[3]),
        .rx_dout(dout_w[3]), .rx_done(done_w[3]), .parity_err(perr_w[3]), .frame_err(ferr_w[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rx_tick  = 1'b0;
        tick_cnt = 0;
        forever begin
            @(negedge clk);
            tick_cnt = (tick_cnt + 1) % TICK_DIV;
            rx_tick  = (tick_cnt == 0);
        end
    end

    function automatic logic has_par(input int idx);
        return (idx == 1) || (idx == 2);
    endfunction

    function automatic logic odd_par(input int idx);
        return idx == 2;
    endfunction

    function automatic int nstop(input int idx);
        return (idx == 3) ? 2 : 1;
    endfunction

    task automatic check(input string name, input int inst, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s inst=%0d got=%0h want=%0h", name, inst, got, want);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_dout"}, i, 32'(dout_w[i]), 32'd0);
            check({tag, "_done"}, i, 32'(done_w[i]), 32'd0);
            check({tag, "_perr"}, i, 32'(perr_w[i]), 32'd0);
            check({tag, "_ferr"}, i, 32'(ferr_w[i]), 32'd0);
        end
    endtask

    task automatic wait_ticks(input int nt);
        for (int k = 0; k < nt; k++) begin
            @(posedge clk);
            while (!rx_tick) @(posedge clk);
        end
    endtask

    task automatic send_bit(input int idx, input logic v, input int nt);
        if (nt > 0) begin
            @(negedge clk);
            rx_line[idx] = v;
            wait_ticks(nt);
        end
    endtask

    // Reference: parity error when the sent bit differs from the one that makes the
    // count of ones even (or odd); frame error when any stop bit is sent low.
    task automatic send_frame(input int idx, input logic [7:0] data, input logic par_bit, input logic [1:0] stops);
        logic perr;
        logic ferr;
        perr = has_par(idx) ? (par_bit != ((^data) ^ odd_par(idx))) : 1'b0;
        ferr = (stops[0] == 1'b0) || ((nstop(idx) == 2) && (stops[1] == 1'b0));
        exp_q[idx].push_back({data, perr, ferr});
        send_bit(idx, 1'b0, 16);
        for (int b = 0; b < 8; b++) send_bit(idx, data[b], 16);
        if (has_par(idx)) send_bit(idx, par_bit, 16);
        for (int s = 0; s < nstop(idx); s++) send_bit(idx, stops[s], 16);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (done_w[i] === 1'b1) begin
                total++;
                if (exp_q[i].size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done inst=%0d got data=%0h perr=%b ferr=%b want no frame",
                             i, dout_w[i], perr_w[i], ferr_w[i]);
                end else begin
                    logic [9:0] e;
                    e = exp_q[i].pop_front();
                    if ({dout_w[i], perr_w[i], ferr_w[i]} !== e) begin
                        bad++;
                        $display("FAIL frame inst=%0d got data=%0h perr=%b ferr=%b want data=%0h perr=%b ferr=%b",
                                 i, dout_w[i], perr_w[i], ferr_w[i], e[9:2], e[1], e[0]);
                    end
                end
            end
        end
    end

    initial begin
        logic [1:0] stops;
        logic       last_stop;
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        rx_line = 4'hF;
        repeat (5) @(negedge clk);
        check_zero_outputs("reset");
        reset = 1'b0;
        repeat (5) @(negedge clk);

        send_frame(0, 8'hA5, 1'b0, 2'b11);
        send_bit(0, 1'b1, 16);

        send_frame(1, 8'h03, 1'b1, 2'b11);
        send_frame(1, 8'h03, 1'b0, 2'b11);
        send_bit(1, 1'b1, 16);

        send_frame(2, 8'h07, 1'b0, 2'b11);
        send_frame(2, 8'h07, 1'b1, 2'b11);
        send_bit(2, 1'b1, 16);

        // Stop bit low followed by a long break: one errored frame, then silence.
        send_frame(0, 8'h55, 1'b0, 2'b10);
        send_bit(0, 1'b0, 16 * 40);
        send_bit(0, 1'b1, 16);

        send_bit(0, 1'b0, 4);
        send_bit(0, 1'b1, 16);
        send_frame(0, 8'h3C, 1'b0, 2'b11);
        send_bit(0, 1'b1, 16);

        // Abort 0xF0 partway through data bit 4.
        send_bit(0, 1'b0, 16);
        for (int b = 0; b < 4; b++) send_bit(0, b[0] & 1'b0, 16);
        send_bit(0, 1'b1, 8);
        @(negedge clk);
        reset      = 1'b1;
        rx_line[0] = 1'b1;
        repeat (3) @(negedge clk);
        check_zero_outputs("midreset");
        reset = 1'b0;
        send_bit(0, 1'b1, 16);
        send_frame(0, 8'h81, 1'b0, 2'b11);
        send_bit(0, 1'b1, 16);

        send_frame(3, 8'h00, 1'b0, 2'b11);
        send_frame(3, 8'hFF, 1'b0, 2'b11);
        send_bit(3, 1'b1, 16);

        for (int r = 0; r < 10; r++) begin
            for (int idx = 0; idx < 4; idx++) begin
                stops = 2'b11;
                if ($urandom_range(0, 3) == 0) stops[$urandom_range(0, 1)] = 1'b0;
                send_frame(idx, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), stops);
                last_stop = (nstop(idx) == 2) ? stops[1] : stops[0];
                if (!last_stop) send_bit(idx, 1'b1, 16);
                send_bit(idx, 1'b1, $urandom_range(0, 24));
            end
        end

        repeat (200) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("missing_done", i, 32'(exp_q[i].size()), 32'd0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
